pop_stack_node: RTL and testbench
=================================

# pop_stack_node

Parametrised synchronous LIFO stack built as a chain of shift-register cells; it generalises the 3-bit pop/push register node to WIDTH bits and DEPTH entries. It adds occupancy tracking, sticky error flags, a push+pop replace-top operation, and a drain mode. Drain mode streams the whole stack, top first, into a parallel node over a valid/ready handshake. It sits in the ant-farm datapath wherever per-ant state is stacked and later handed to a neighbouring stack.

## Interface
Parameters:
- WIDTH, 3, bits per entry
- DEPTH, 8, number of entries (≥2)
- CW, $clog2(DEPTH+1), derived local width of count; not overridable

Ports (one clock `clk`; reset `reset` is synchronous, active-high):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- push  in  1  push data_in onto top
- pop  in  1  remove top entry
- data_in  in  WIDTH  value to push
- drain  in  1  one-cycle request to stream the entire stack out on down_*
- clear_err  in  1  clears overflow/underflow
- top  out  WIDTH  current top entry (entry 0); 0 when empty
- count  out  CW  number of valid entries, 0..DEPTH
- empty  out  1  count==0
- full  out  1  count==DEPTH
- busy  out  1  high while in DRAIN
- overflow  out  1  sticky: push attempted while full
- underflow  out  1  sticky: pop attempted while empty
- down_data  out  WIDTH  drain data (equals top while down_valid)
- down_valid  out  1  drain word available
- down_ready  in  1  receiver accepts down_data

## Operation
- Storage: entry[0] is the top, entry[DEPTH-1] the bottom. A push shifts every entry down one place and loads data_in into entry[0]. A pop shifts every entry up one place and loads 0 into entry[DEPTH-1]. Unused entries always hold 0.
- FSM states: IDLE, DRAIN.
- In IDLE, the action for each {push,pop} combination is:
  - 00: hold.
  - 10: if !full, push and count+1. If full, the stack is unchanged and overflow←1.
  - 01: if !empty, pop and count−1. If empty, the stack is unchanged and underflow←1.
  - 11: if !empty, replace: entry[0]←data_in with no shift and count unchanged. If empty, this behaves as a push (count←1) with no error.
- drain in IDLE:
  - If count>0, go to DRAIN. drain takes priority over push/pop in the same cycle, and that push/pop is discarded.
  - If empty, drain is a no-op and the block stays in IDLE.
- In DRAIN:
  - busy=1, down_valid=1, down_data=entry[0].
  - On each cycle with down_ready=1, the block pops and decrements count. When the transfer takes count from 1 to 0, the next state is IDLE.
  - push, pop and drain are ignored in DRAIN and set no error flags.
- clear_err clears both sticky flags on the next edge. An error event in the same cycle wins, and the flag stays 1.
- Count arithmetic: CW bits, no wrap; count never leaves 0..DEPTH.
- Reset (also mid-DRAIN): all entries 0, count 0, state IDLE. All outputs become 0 except empty=1: top, count, full, busy, overflow, underflow, down_valid and down_data are 0.

## Timing
- All state updates on the rising edge of clk; no combinational input→output paths except:
  - top is a direct view of entry[0].
  - down_valid and down_data are decoded from state and entry[0], registered sources only.
- Push/pop latency: one cycle; top, count, empty and full reflect the operation after the edge.
- Drain: first word is valid the cycle after drain is sampled. With down_ready held at 1, N entries drain in N cycles; busy falls in the cycle after the last transfer.
- Handshake: down_data must stay stable while down_valid=1 and down_ready=0. down_valid never drops without a transfer, except on reset.

## Structure
- Shared package `stack_pkg`:
  - state enum `stack_state_t` {IDLE, DRAIN}
  - op encoding constants OP_HOLD, OP_PUSH, OP_POP, OP_REPL for {push,pop} after qualification
- Sub-module `stack_cell`: one WIDTH-bit register with a hold / load-from-above / load-from-below / load-data_in mux and synchronous reset. It is instantiated DEPTH times with a generate loop. Cell DEPTH-1 takes 0 from below; cell 0 takes data_in from above.
- Top level holds the FSM, count, flags and per-cell select generation.

## Test plan
- Reset then push 1,2,3 (WIDTH=3, DEPTH=8): expect top=3, count=3. Pop twice: expect top=1, count=1, with empty and full both 0.
- Push 8 values, then push 5: expect full=1, overflow=1, count=8, top unchanged. Assert clear_err: overflow=0 next cycle.
- From empty, pop: expect underflow=1, count=0. Then push+pop with data 6: expect count=1, top=6, no new error. Then push+pop with data 2: expect top=2, count=1.
- Push 4,5,7, then drain with down_ready=1: expect down_data 7,5,4 on consecutive cycles, busy for 3 cycles, then empty=1 and state IDLE.
- Drain with down_ready toggling 0/1: down_data holds while ready=0 and every word is delivered exactly once in LIFO order. Push/pop asserted during DRAIN has no effect and sets no flags.
- Assert reset mid-drain with 2 of 5 words sent: next cycle count=0, down_valid=0, busy=0, top=0; a subsequent push 3 gives top=3, count=1.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared types and encodings for the pop/push LIFO stack node.
package stack_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } stack_state_t;

   // Qualified {push,pop} operation encodings.
   localparam logic [1:0] OP_HOLD = 2'b00;
   localparam logic [1:0] OP_PUSH = 2'b10;
   localparam logic [1:0] OP_POP  = 2'b01;
   localparam logic [1:0] OP_REPL = 2'b11;

   // Per-cell load select.
   localparam logic [1:0] CELL_HOLD  = 2'd0;
   localparam logic [1:0] CELL_ABOVE = 2'd1;
   localparam logic [1:0] CELL_BELOW = 2'd2;
   localparam logic [1:0] CELL_DATA  = 2'd3;

endpackage

// File: rtl/stack_cell.sv
// One stack entry: a WIDTH-bit register loading from hold, the entry above,
// the entry below, or the external data word.
module stack_cell #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       sel,
   input  logic [WIDTH-1:0] above,
   input  logic [WIDTH-1:0] below,
   input  logic [WIDTH-1:0] load_data,
   output logic [WIDTH-1:0] q
);
   import stack_pkg::*;

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= '0;
      end else begin
         case (sel)
            CELL_ABOVE: q <= above;
            CELL_BELOW: q <= below;
            CELL_DATA:  q <= load_data;
            default:    q <= q;
         endcase
      end
   end

endmodule

// File: rtl/pop_stack_node.sv
// Parametrised shift-register LIFO with occupancy, sticky error flags,
// replace-top and a drain mode streaming the stack out over valid/ready.
module pop_stack_node #(
   parameter int  WIDTH = 3,
   parameter int  DEPTH = 8,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] data_in,
   input  logic             drain,
   input  logic             clear_err,
   output logic [WIDTH-1:0] top,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full,
   output logic             busy,
   output logic             overflow,
   output logic             underflow,
   output logic [WIDTH-1:0] down_data,
   output logic             down_valid,
   input  logic             down_ready
);
   import stack_pkg::*;

   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   stack_state_t     state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic             ovf_q, ovf_d, unf_q, unf_d;
   logic [1:0]       top_sel, body_sel;
   logic [WIDTH-1:0] entry [DEPTH];

   assign empty = (count_q == '0);
   assign full  = (count_q == FULL_CNT);

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      top_sel  = CELL_HOLD;
      body_sel = CELL_HOLD;
      ovf_d    = clear_err ? 1'b0 : ovf_q;
      unf_d    = clear_err ? 1'b0 : unf_q;
      case (state_q)
         IDLE: begin
            // A drain on a non-empty stack pre-empts any push/pop this cycle.
            if (drain && !empty) begin
               state_d = DRAIN;
            end else begin
               case ({push, pop})
                  OP_PUSH: begin
                     if (!full) begin
                        top_sel  = CELL_ABOVE;
                        body_sel = CELL_ABOVE;
                        count_d  = count_q + CW'(1);
                     end else begin
                        ovf_d = 1'b1;
                     end
                  end
                  OP_POP: begin
                     if (!empty) begin
                        top_sel  = CELL_BELOW;
                        body_sel = CELL_BELOW;
                        count_d  = count_q - CW'(1);
                     end else begin
                        unf_d = 1'b1;
                     end
                  end
                  OP_REPL: begin
                     top_sel = CELL_DATA;
                     if (empty) count_d = CW'(1);
                  end
                  default: ;
               endcase
            end
         end
         DRAIN: begin
            if (down_ready) begin
               top_sel  = CELL_BELOW;
               body_sel = CELL_BELOW;
               count_d  = count_q - CW'(1);
               if (count_q == CW'(1)) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_cell
      logic [WIDTH-1:0] above_v, below_v;
      if (i == 0) begin : g_first
         assign above_v = data_in;
      end else begin : g_rest
         assign above_v = entry[i-1];
      end
      if (i == DEPTH - 1) begin : g_last
         assign below_v = '0;
      end else begin : g_inner
         assign below_v = entry[i+1];
      end
      stack_cell #(
         .WIDTH(WIDTH)
      ) u_cell (
         .clk      (clk),
         .reset    (reset),
         .sel      ((i == 0) ? top_sel : body_sel),
         .above    (above_v),
         .below    (below_v),
         .load_data(data_in),
         .q        (entry[i])
      );
   end

   assign top        = entry[0];
   assign count      = count_q;
   assign busy       = (state_q == DRAIN);
   assign down_valid = busy;
   assign down_data  = busy ? entry[0] : '0;
   assign overflow   = ovf_q;
   assign underflow  = unf_q;

endmodule

// File: tb/tb_pop_stack_node.sv
// Self-checking bench for pop_stack_node with a drain-word scoreboard.
module tb_pop_stack_node;

   localparam int W  = 3;
   localparam int D  = 8;
   localparam int CW = $clog2(D + 1);

   logic          clk = 1'b0;
   logic          reset, push, pop, drain, clear_err, down_ready;
   logic [W-1:0]  data_in, top, down_data;
   logic [CW-1:0] count;
   logic          empty, full, busy, overflow, underflow, down_valid;

   int pass_cnt  = 0;
   int total_cnt = 0;
   logic [W-1:0] exp_q [$];

   always #5 clk = ~clk;

   pop_stack_node #(
      .WIDTH(W),
      .DEPTH(D)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .data_in   (data_in),
      .drain     (drain),
      .clear_err (clear_err),
      .top       (top),
      .count     (count),
      .empty     (empty),
      .full      (full),
      .busy      (busy),
      .overflow  (overflow),
      .underflow (underflow),
      .down_data (down_data),
      .down_valid(down_valid),
      .down_ready(down_ready)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic p, input logic q, input logic [W-1:0] d);
      push = p; pop = q; data_in = d;
      tick();
      push = 1'b0; pop = 1'b0; data_in = '0;
   endtask

   // Pushed words go to the scoreboard front: drain must return them top first.
   task automatic push_val(input logic [W-1:0] d);
      exp_q.push_front(d);
      drive(1'b1, 1'b0, d);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_q.delete();
   endtask

   task automatic start_drain();
      drain = 1'b1;
      tick();
      drain = 1'b0;
   endtask

   task automatic test_reset();
      total_cnt++; if (top !== 3'd0) $display("FAIL rst_top: got %0d want 0", top); else pass_cnt++;
      total_cnt++; if (count !== CW'(0)) $display("FAIL rst_count: got %0d want 0", count); else pass_cnt++;
      total_cnt++; if (empty !== 1'b1) $display("FAIL rst_empty: got %b want 1", empty); else pass_cnt++;
      total_cnt++; if (full !== 1'b0) $display("FAIL rst_full: got %b want 0", full); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (overflow !== 1'b0) $display("FAIL rst_ovf: got %b want 0", overflow); else pass_cnt++;
      total_cnt++; if (underflow !== 1'b0) $display("FAIL rst_unf: got %b want 0", underflow); else pass_cnt++;
      total_cnt++; if (down_valid !== 1'b0) $display("FAIL rst_dvalid: got %b want 0", down_valid); else pass_cnt++;
      total_cnt++; if (down_data !== 3'd0) $display("FAIL rst_ddata: got %0d want 0", down_data); else pass_cnt++;
   endtask

   task automatic test_push_pop();
      apply_reset();
      push_val(3'd1); push_val(3'd2); push_val(3'd3);
      total_cnt++; if (top !== 3'd3) $display("FAIL pp_top3: got %0d want 3", top); else pass_cnt++;
      total_cnt++; if (count !== CW'(3)) $display("FAIL pp_count3: got %0d want 3", count); else pass_cnt++;
      drive(1'b0, 1'b1, '0);
      drive(1'b0, 1'b1, '0);
      total_cnt++; if (top !== 3'd1) $display("FAIL pp_top1: got %0d want 1", top); else pass_cnt++;
      total_cnt++; if (count !== CW'(1)) $display("FAIL pp_count1: got %0d want 1", count); else pass_cnt++;
      total_cnt++; if (empty !== 1'b0 || full !== 1'b0)
         $display("FAIL pp_flags: got empty=%b full=%b want 0 0", empty, full); else pass_cnt++;
      drive(1'b0, 1'b1, '0);
      total_cnt++; if (empty !== 1'b1 || top !== 3'd0)
         $display("FAIL pp_drained: got empty=%b top=%0d want 1 0", empty, top); else pass_cnt++;
      total_cnt++; if (underflow !== 1'b0) $display("FAIL pp_no_unf: got %b want 0", underflow); else pass_cnt++;
   endtask

   task automatic test_overflow();
      logic [W-1:0] want;
      apply_reset();
      for (int i = 1; i <= 7; i++) drive(1'b1, 1'b0, W'(i));
      drive(1'b1, 1'b0, 3'd6);
      total_cnt++; if (full !== 1'b1 || count !== CW'(8))
         $display("FAIL ov_full: got full=%b count=%0d want 1 8", full, count); else pass_cnt++;
      drive(1'b1, 1'b0, 3'd5);
      total_cnt++; if (overflow !== 1'b1) $display("FAIL ov_flag: got %b want 1", overflow); else pass_cnt++;
      total_cnt++; if (count !== CW'(8) || top !== 3'd6)
         $display("FAIL ov_unchanged: got count=%0d top=%0d want 8 6", count, top); else pass_cnt++;
      clear_err = 1'b1; tick(); clear_err = 1'b0;
      total_cnt++; if (overflow !== 1'b0) $display("FAIL ov_clear: got %b want 0", overflow); else pass_cnt++;
      clear_err = 1'b1; drive(1'b1, 1'b0, 3'd5); clear_err = 1'b0;
      total_cnt++; if (overflow !== 1'b1) $display("FAIL ov_err_wins: got %b want 1", overflow); else pass_cnt++;
      clear_err = 1'b1; tick(); clear_err = 1'b0;
      // Stack is 6,7,6,5,4,3,2,1 top to bottom.
      for (int j = 1; j <= 8; j++) begin
         drive(1'b0, 1'b1, '0);
         want = (j == 1) ? 3'd7 : ((j == 8) ? 3'd0 : W'(8 - j));
         total_cnt++; if (top !== want || count !== CW'(8 - j))
            $display("FAIL ov_pop%0d: got top=%0d count=%0d want %0d %0d", j, top, count, want, 8 - j);
         else pass_cnt++;
      end
      drive(1'b0, 1'b1, '0);
      total_cnt++; if (underflow !== 1'b1 || overflow !== 1'b0)
         $display("FAIL ov_then_unf: got unf=%b ovf=%b want 1 0", underflow, overflow); else pass_cnt++;
   endtask

   task automatic test_underflow_replace();
      apply_reset();
      drive(1'b0, 1'b1, '0);
      total_cnt++; if (underflow !== 1'b1 || count !== CW'(0))
         $display("FAIL un_flag: got unf=%b count=%0d want 1 0", underflow, count); else pass_cnt++;
      drive(1'b1, 1'b1, 3'd6);
      total_cnt++; if (count !== CW'(1) || top !== 3'd6)
         $display("FAIL rp_empty: got count=%0d top=%0d want 1 6", count, top); else pass_cnt++;
      total_cnt++; if (overflow !== 1'b0 || underflow !== 1'b1)
         $display("FAIL rp_noerr: got ovf=%b unf=%b want 0 1", overflow, underflow); else pass_cnt++;
      drive(1'b1, 1'b1, 3'd2);
      total_cnt++; if (count !== CW'(1) || top !== 3'd2)
         $display("FAIL rp_one: got count=%0d top=%0d want 1 2", count, top); else pass_cnt++;
      drive(1'b1, 1'b0, 3'd5);
      drive(1'b1, 1'b1, 3'd3);
      total_cnt++; if (count !== CW'(2) || top !== 3'd3)
         $display("FAIL rp_two: got count=%0d top=%0d want 2 3", count, top); else pass_cnt++;
      drive(1'b0, 1'b1, '0);
      total_cnt++; if (top !== 3'd2) $display("FAIL rp_noshift: got %0d want 2", top); else pass_cnt++;
      clear_err = 1'b1; tick(); clear_err = 1'b0;
      total_cnt++; if (underflow !== 1'b0) $display("FAIL un_clear: got %b want 0", underflow); else pass_cnt++;
   endtask

   task automatic test_drain();
      int guard, busy_cycles;
      logic [W-1:0] want;
      apply_reset();
      push_val(3'd4); push_val(3'd5); push_val(3'd7);
      down_ready = 1'b1;
      push = 1'b1; data_in = 3'd1;
      start_drain();
      push = 1'b0; data_in = '0;
      total_cnt++; if (busy !== 1'b1 || count !== CW'(3))
         $display("FAIL dr_start: got busy=%b count=%0d want 1 3", busy, count); else pass_cnt++;
      guard = 0; busy_cycles = 0;
      while (down_valid && guard < 20) begin
         if (exp_q.size() == 0) begin
            total_cnt++; $display("FAIL dr_extra: got %0d want none", down_data);
         end else begin
            want = exp_q.pop_front();
            total_cnt++; if (down_data !== want)
               $display("FAIL dr_word: got %0d want %0d", down_data, want); else pass_cnt++;
         end
         busy_cycles++;
         tick(); guard++;
      end
      total_cnt++; if (guard >= 20) $display("FAIL dr_timeout: got %0d cycles want <20", guard); else pass_cnt++;
      total_cnt++; if (busy_cycles != 3) $display("FAIL dr_busy_len: got %0d want 3", busy_cycles); else pass_cnt++;
      total_cnt++; if (exp_q.size() != 0) $display("FAIL dr_missing: got %0d left want 0", exp_q.size()); else pass_cnt++;
      total_cnt++; if (empty !== 1'b1 || busy !== 1'b0)
         $display("FAIL dr_end: got empty=%b busy=%b want 1 0", empty, busy); else pass_cnt++;
      start_drain();
      total_cnt++; if (busy !== 1'b0 || down_valid !== 1'b0)
         $display("FAIL dr_empty_noop: got busy=%b valid=%b want 0 0", busy, down_valid); else pass_cnt++;
      down_ready = 1'b0;
   endtask

   task automatic test_drain_backpressure();
      int guard, k;
      logic hold_chk;
      logic [W-1:0] held, want;
      apply_reset();
      push_val(3'd1); push_val(3'd2); push_val(3'd3); push_val(3'd6); push_val(3'd5);
      down_ready = 1'b0;
      start_drain();
      guard = 0; k = 0; hold_chk = 1'b0; held = '0;
      while (down_valid && guard < 40) begin
         if (hold_chk) begin
            total_cnt++; if (down_data !== held)
               $display("FAIL bp_hold: got %0d want %0d", down_data, held); else pass_cnt++;
         end
         down_ready = k[0]; push = 1'b1; pop = k[1]; drain = k[2]; data_in = 3'd7;
         if (down_ready) begin
            hold_chk = 1'b0;
            if (exp_q.size() == 0) begin
               total_cnt++; $display("FAIL bp_extra: got %0d want none", down_data);
            end else begin
               want = exp_q.pop_front();
               total_cnt++; if (down_data !== want)
                  $display("FAIL bp_word: got %0d want %0d", down_data, want); else pass_cnt++;
            end
         end else begin
            held = down_data; hold_chk = 1'b1;
         end
         k++;
         tick(); guard++;
      end
      push = 1'b0; pop = 1'b0; drain = 1'b0; down_ready = 1'b0; data_in = '0;
      total_cnt++; if (guard >= 40) $display("FAIL bp_timeout: got %0d cycles want <40", guard); else pass_cnt++;
      total_cnt++; if (exp_q.size() != 0) $display("FAIL bp_missing: got %0d left want 0", exp_q.size()); else pass_cnt++;
      total_cnt++; if (overflow !== 1'b0 || underflow !== 1'b0)
         $display("FAIL bp_noflags: got ovf=%b unf=%b want 0 0", overflow, underflow); else pass_cnt++;
      total_cnt++; if (empty !== 1'b1 || count !== CW'(0))
         $display("FAIL bp_end: got empty=%b count=%0d want 1 0", empty, count); else pass_cnt++;
   endtask

   task automatic test_reset_mid_drain();
      apply_reset();
      for (int i = 1; i <= 5; i++) push_val(W'(i));
      down_ready = 1'b0;
      start_drain();
      down_ready = 1'b1;
      tick(); tick();
      total_cnt++; if (count !== CW'(3) || down_data !== 3'd3)
         $display("FAIL md_partial: got count=%0d data=%0d want 3 3", count, down_data); else pass_cnt++;
      apply_reset();
      down_ready = 1'b0;
      total_cnt++; if (count !== CW'(0) || down_valid !== 1'b0 || busy !== 1'b0)
         $display("FAIL md_reset: got count=%0d valid=%b busy=%b want 0 0 0", count, down_valid, busy);
      else pass_cnt++;
      total_cnt++; if (top !== 3'd0 || empty !== 1'b1 || down_data !== 3'd0)
         $display("FAIL md_reset_data: got top=%0d empty=%b data=%0d want 0 1 0", top, empty, down_data);
      else pass_cnt++;
      drive(1'b1, 1'b0, 3'd3);
      total_cnt++; if (top !== 3'd3 || count !== CW'(1))
         $display("FAIL md_repush: got top=%0d count=%0d want 3 1", top, count); else pass_cnt++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; push = 1'b0; pop = 1'b0; drain = 1'b0; clear_err = 1'b0;
      down_ready = 1'b0; data_in = '0;
      tick(); tick();
      reset = 1'b0;
      test_reset();
      test_push_pop();
      test_overflow();
      test_underflow_replace();
      test_drain();
      test_drain_backpressure();
      test_reset_mid_drain();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
